// File: rtl/nand_pkg.sv
// Shared definitions for the NAND page-program sequencer.
// Contents:
//   phase_e      - phase codes driven on the datapath 'state' bus
//   RES_*        - completion result codes
//   ROW_*, WS_*  - encodings of the datapath row-check and program-status inputs
//   CMD_*        - ONFI command bytes the datapath emits for each phase
//   *_DEF        - default page geometry
package nand_pkg;

  typedef enum logic [4:0] {
    PH_IDLE       = 5'd0,
    PH_CHECK      = 5'd6,
    PH_CMD_START  = 5'd7,
    PH_ADDR       = 5'd8,
    PH_DATA       = 5'd9,
    PH_CMD_FINISH = 5'd10,
    PH_WAIT_RB    = 5'd15,
    PH_STATUS     = 5'd16,
    PH_SKIP       = 5'd17
  } phase_e;

  localparam logic [1:0] RES_OK            = 2'd0;
  localparam logic [1:0] RES_PROG_FAIL     = 2'd1;
  localparam logic [1:0] RES_NO_GOOD_BLOCK = 2'd2;
  localparam logic [1:0] RES_RB_TIMEOUT    = 2'd3;

  localparam logic [1:0] ROW_PENDING = 2'd0;
  localparam logic [1:0] ROW_GOOD    = 2'd1;
  localparam logic [1:0] ROW_BAD     = 2'd2;

  localparam logic [1:0] WS_PENDING = 2'd0;
  localparam logic [1:0] WS_PASS    = 2'd1;
  localparam logic [1:0] WS_FAIL    = 2'd2;

  localparam logic [7:0] CMD_PROG_SETUP   = 8'h80;
  localparam logic [7:0] CMD_PROG_CONFIRM = 8'h10;
  localparam logic [7:0] CMD_READ_STATUS  = 8'h70;

  localparam int PAGE_BYTES_DEF = 8192;
  localparam int ECC_BYTES_DEF  = 192;
  localparam int ADDR_BYTES     = 5;

endpackage

// File: rtl/nand_byte_timer.sv
// Byte-period timer for the flash write strobe.
// While enabled, repeats a period of T_LOW cycles with tWrite=0 followed by
// T_HIGH cycles with tWrite=1. Disabling it parks the counter at the start of
// a period so the next enable begins a fresh byte.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - run the timer
//   tWrite      - byte strobe (0 = we_n low portion)
//   byte_start  - first cycle of a byte period
//   byte_end    - last cycle of a byte period
module nand_byte_timer #(
  parameter int T_LOW  = 6,
  parameter int T_HIGH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tWrite,
  output logic byte_start,
  output logic byte_end
);

  localparam int PERIOD = T_LOW + T_HIGH;
  localparam int CW     = $clog2(PERIOD);

  logic [CW-1:0] cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= '0;
    end else if (!en || byte_end) begin
      cyc <= '0;
    end else begin
      cyc <= cyc + CW'(1);
    end
  end

  assign byte_start = en && (cyc == '0);
  assign byte_end   = en && (cyc == CW'(PERIOD - 1));
  assign tWrite     = en && (cyc >= CW'(T_LOW));

endmodule

// File: rtl/nand_page_write_seq.sv
// Single-page NAND program sequencer.
// Accepts a host request, resolves a good block through the bad-block check
// (skipping forward block by block), then walks the write datapath through
// command, address, data+ECC, confirm, tWB, ready/busy wait and status phases.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   req, req_row          - start request (IDLE only) and target row
//   busy, done            - operation in progress / one-cycle completion pulse
//   result, row_used      - outcome and programmed row, valid with done
//   data_req              - pulse requesting the next host data byte
//   state, tWrite,
//   write_data_cnt,
//   en_write_page,
//   addr_row              - control bundle for the write datapath
//   write_addr_row_error  - bad-block lookup result from the datapath
//   write_success,
//   write_complete        - program status from the datapath
//   rb_n                  - flash ready/busy (synchronised)
//   ce_n, cle, ale,
//   we_n, re_n            - flash control pins
module nand_page_write_seq
  import nand_pkg::*;
#(
  parameter int T_LOW           = 6,
  parameter int T_HIGH          = 2,
  parameter int PAGE_BYTES      = PAGE_BYTES_DEF,
  parameter int ECC_BYTES       = ECC_BYTES_DEF,
  parameter int PAGES_PER_BLOCK = 128,
  parameter int MAX_SKIP        = 4,
  parameter int T_WB            = 10,
  parameter int RB_TIMEOUT      = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [23:0] req_row,
  output logic        busy,
  output logic        done,
  output logic [1:0]  result,
  output logic [23:0] row_used,
  output logic        data_req,
  output logic [4:0]  state,
  output logic        tWrite,
  output logic [13:0] write_data_cnt,
  output logic        en_write_page,
  output logic [23:0] addr_row,
  input  logic [1:0]  write_addr_row_error,
  input  logic [1:0]  write_success,
  input  logic        write_complete,
  input  logic        rb_n,
  output logic        ce_n,
  output logic        cle,
  output logic        ale,
  output logic        we_n,
  output logic        re_n
);

  localparam int          TOTAL_BYTES = PAGE_BYTES + ECC_BYTES;
  localparam int          WAIT_W      = $clog2(RB_TIMEOUT + T_WB + 1);
  localparam int          SKIP_W      = $clog2(MAX_SKIP + 1);
  localparam logic [23:0] BLK_MASK    = 24'(PAGES_PER_BLOCK - 1);

  phase_e              phase, phase_d;
  logic [13:0]         cnt_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_d;
  logic [SKIP_W-1:0]   skip_cnt, skip_d;
  logic [23:0]         addr_d;
  logic                wb, wb_d;
  logic                finish;
  logic [1:0]          finish_res;
  logic                timer_en, byte_start, byte_end;

  // The timer only runs while a byte is actually being clocked onto the bus;
  // the tWB gap at the end of CMD_FINISH keeps it parked.
  assign timer_en = (phase == PH_CMD_START) || (phase == PH_ADDR) ||
                    (phase == PH_DATA) || ((phase == PH_CMD_FINISH) && !wb);

  nand_byte_timer #(
    .T_LOW  (T_LOW),
    .T_HIGH (T_HIGH)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (timer_en),
    .tWrite     (tWrite),
    .byte_start (byte_start),
    .byte_end   (byte_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase          <= PH_IDLE;
      write_data_cnt <= '0;
      wait_cnt       <= '0;
      skip_cnt       <= '0;
      addr_row       <= '0;
      wb             <= 1'b0;
      done           <= 1'b0;
      result         <= RES_OK;
      row_used       <= '0;
    end else begin
      phase          <= phase_d;
      write_data_cnt <= cnt_d;
      wait_cnt       <= wait_d;
      skip_cnt       <= skip_d;
      addr_row       <= addr_d;
      wb             <= wb_d;
      done           <= finish;
      if (finish) begin
        result   <= finish_res;
        row_used <= addr_d;
      end
    end
  end

  always_comb begin
    phase_d    = phase;
    cnt_d      = write_data_cnt;
    wait_d     = wait_cnt;
    skip_d     = skip_cnt;
    addr_d     = addr_row;
    wb_d       = wb;
    finish     = 1'b0;
    finish_res = RES_OK;
    case (phase)
      PH_IDLE: begin
        if (req) begin
          addr_d  = req_row;
          skip_d  = '0;
          phase_d = PH_CHECK;
        end
      end
      PH_CHECK: begin
        if (write_addr_row_error == ROW_GOOD) begin
          phase_d = PH_CMD_START;
        end else if (write_addr_row_error == ROW_BAD) begin
          phase_d = PH_SKIP;
        end
      end
      PH_SKIP: begin
        // Jump to page 0 of the next block; dropping en_write_page for this
        // cycle lets the datapath restart its lookup on the new row.
        addr_d = (addr_row & ~BLK_MASK) + 24'(PAGES_PER_BLOCK);
        skip_d = skip_cnt + SKIP_W'(1);
        if (skip_cnt == SKIP_W'(MAX_SKIP - 1)) begin
          finish     = 1'b1;
          finish_res = RES_NO_GOOD_BLOCK;
          phase_d    = PH_IDLE;
        end else begin
          phase_d = PH_CHECK;
        end
      end
      PH_CMD_START: begin
        if (byte_end) begin
          cnt_d   = '0;
          phase_d = PH_ADDR;
        end
      end
      PH_ADDR: begin
        if (byte_end) begin
          if (write_data_cnt == 14'(ADDR_BYTES - 1)) begin
            cnt_d   = '0;
            phase_d = PH_DATA;
          end else begin
            cnt_d = write_data_cnt + 14'd1;
          end
        end
      end
      PH_DATA: begin
        // The final index is held rather than wrapped so the datapath sees
        // the last ECC byte position until the next page starts.
        if (byte_end) begin
          if (write_data_cnt == 14'(TOTAL_BYTES - 1)) begin
            wb_d    = 1'b0;
            phase_d = PH_CMD_FINISH;
          end else begin
            cnt_d = write_data_cnt + 14'd1;
          end
        end
      end
      PH_CMD_FINISH: begin
        if (!wb) begin
          if (byte_end) begin
            wb_d   = 1'b1;
            wait_d = '0;
          end
        end else if (wait_cnt == WAIT_W'(T_WB - 1)) begin
          wb_d    = 1'b0;
          wait_d  = '0;
          phase_d = PH_WAIT_RB;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      PH_WAIT_RB: begin
        if (rb_n) begin
          phase_d = PH_STATUS;
        end else if (wait_cnt == WAIT_W'(RB_TIMEOUT - 1)) begin
          finish     = 1'b1;
          finish_res = RES_RB_TIMEOUT;
          phase_d    = PH_IDLE;
        end else begin
          wait_d = wait_cnt + WAIT_W'(1);
        end
      end
      PH_STATUS: begin
        if (write_complete) begin
          finish     = 1'b1;
          finish_res = (write_success == WS_PASS) ? RES_OK : RES_PROG_FAIL;
          phase_d    = PH_IDLE;
        end
      end
      default: begin
        phase_d = PH_IDLE;
      end
    endcase
  end

  assign state         = phase;
  assign busy          = (phase != PH_IDLE);
  assign en_write_page = (phase != PH_IDLE) && (phase != PH_SKIP);
  assign data_req      = (phase == PH_DATA) && byte_start &&
                         (write_data_cnt < 14'(PAGE_BYTES));
  assign ce_n          = !((phase == PH_CMD_START) || (phase == PH_ADDR) ||
                           (phase == PH_DATA) || (phase == PH_CMD_FINISH) ||
                           (phase == PH_WAIT_RB) || (phase == PH_STATUS));
  assign cle           = (phase == PH_CMD_START) || ((phase == PH_CMD_FINISH) && !wb);
  assign ale           = (phase == PH_ADDR);
  assign we_n          = !(timer_en && !tWrite);
  assign re_n          = (phase != PH_STATUS);

endmodule

// File: doc/nand_page_write_seq.md
# nand_page_write_seq

Sequencer for single-page NAND program operations: accepts a host page-write request, checks the target block against the bad-block table, then steps the write datapath through command, address, data, ECC, confirm, busy-wait and status phases. It generates the `state` code, `tWrite` byte strobe, byte counter and `en_write_page` enable consumed by `write_flash`, and drives the flash control pins. It sits between the host/buffer logic and `write_flash`.

## Interface
- T_LOW, 6, cycles `tWrite`=0 per byte (we_n low); ≥5 so the datapath ECC-RAM update completes
- T_HIGH, 2, cycles `tWrite`=1 per byte (we_n high)
- PAGE_BYTES, 8192, data bytes per page
- ECC_BYTES, 192, ECC bytes appended (64 × 3)
- PAGES_PER_BLOCK, 128, rows per block (block index = row[18:7])
- MAX_SKIP, 4, bad blocks skipped before giving up
- T_WB, 10, cycles after confirm before sampling rb_n
- RB_TIMEOUT, 2_000_000, max cycles waiting for rb_n
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  start request, sampled in IDLE only
- req_row  in  24  requested row address
- busy  out  1  high from accept until done
- done  out  1  one-cycle pulse at completion
- result  out  2  0 ok, 1 program fail, 2 no good block, 3 rb timeout; valid with done
- row_used  out  24  row actually programmed; valid with done
- data_req  out  1  one-cycle pulse requesting next host byte (data phase only)
- state  out  5  phase code to datapath
- tWrite  out  1  byte strobe to datapath
- write_data_cnt  out  14  byte index to datapath
- en_write_page  out  1  datapath enable
- addr_row  out  24  row address to datapath
- write_addr_row_error  in  2  0 pending, 1 good, 2 bad
- write_success  in  2  0 pending, 1 pass, 2 fail
- write_complete  in  1  status evaluation done
- rb_n  in  1  flash ready/busy (1 = ready), already synchronised
- ce_n, cle, ale, we_n, re_n  out  1 each  flash control pins

## Operation
- Phase codes (on `state`): IDLE 0, CHECK 6, CMD_START 7, ADDR 8, DATA 9, CMD_FINISH 10, WAIT_RB 15, STATUS 16, SKIP 17.
- IDLE: en_write_page=0, ce_n=1; on req: addr_row←req_row, busy=1, en_write_page=1 → CHECK.
- CHECK: wait for write_addr_row_error≠0. 1 → CMD_START. 2 → SKIP.
- SKIP: addr_row←{addr_row[23:7]+1, 7'b0}, en_write_page=0 for one cycle, skip count+1; count = MAX_SKIP → done, result 2; else → CHECK with en_write_page=1.
- CMD_START: one byte period, cle=1 → ADDR.
- ADDR: 5 byte periods, ale=1, write_data_cnt=0..4 (2 column, 3 row bytes) → DATA.
- DATA: write_data_cnt 0..PAGE_BYTES+ECC_BYTES−1; cnt<8192 host data, cnt≥8192 ECC bytes from datapath. data_req pulses on the first cycle of each byte period with cnt<PAGE_BYTES. After last byte → CMD_FINISH.
- CMD_FINISH: one byte period, cle=1, then T_WB idle cycles → WAIT_RB.
- WAIT_RB: rb_n=1 → STATUS; counter reaching RB_TIMEOUT → done, result 3.
- STATUS: issue 0x70 read, re_n low; wait write_complete=1; write_success 1 → result 0, 2 → result 1; done, → IDLE.
- On done: en_write_page=0, busy=0, row_used=addr_row.

## Timing
- Reset values: every output 0 except ce_n, we_n, re_n = 1; state = 0.
- Byte period = T_LOW+T_HIGH cycles: tWrite=0 for T_LOW then 1 for T_HIGH; we_n = ~(~tWrite & write phase); write_data_cnt increments on the last T_HIGH cycle.
- Full page: 1+5+8384+1 byte periods = 67 128 cycles at defaults, plus CHECK/WB/RB/STATUS.
- Accept latency: req in IDLE → busy next cycle. req while busy is ignored.
- write_data_cnt resets to 0 on entry to ADDR and DATA; never wraps past 8383.
- A row error pending in CHECK holds indefinitely. No timeout.
- rst_n low at any point forces IDLE and reset values immediately. done does not pulse.

## Structure
- Shared package `nand_pkg`: phase-code localparams, result codes, command bytes (0x80, 0x10, 0x70), PAGE_BYTES/ECC_BYTES defaults.
- One sub-module `nand_byte_timer`: generates tWrite/byte-end from T_LOW/T_HIGH, enabled per phase.

## Test plan
- Good block, row 0x000085, success=1 → 5 ALE bytes, 8192 data_req pulses, cnt ends 8383, done with result 0, row_used 0x000085.
- Block bad twice then good, req_row 0x000105 → row_used 0x000200, result 0, two SKIP visits.
- All blocks bad → after 4 skips done, result 2, no CLE pulse.
- success=2 → result 1.
- rb_n held low → done at RB_TIMEOUT, result 3 (use RB_TIMEOUT=100 in bench).
- rst_n asserted mid-DATA at cnt 3000 → all outputs at reset values same cycle, no done. New req restarts cleanly.
